// File: rtl/dda_spi_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the DDA SPI host and responder: frame size, FSM state codes
// and default timing parameters.
package dda_spi_pkg;

  localparam int FRAME_BITS      = 32;
  localparam int CLK_DIV_DEFAULT = 4;
  localparam int CS_GAP_DEFAULT  = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/spi_tick_gen.sv
`timescale 1ns/1ps
// Half-period divider: tick is high on the CLK_DIV-th cycle after clr drops,
// then every CLK_DIV cycles.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] CNT_PRE  = 8'(CLK_DIV - 2);
  localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_r;
  logic       tick_r;

  // Divider counter with registered tick, restarted by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= 8'd0;
      tick_r <= 1'b0;
    end else if (clr) begin
      cnt_r  <= 8'd0;
      tick_r <= 1'b0;
    end else begin
      tick_r <= (cnt_r == CNT_PRE);
      cnt_r  <= (cnt_r == CNT_LAST) ? 8'd0 : cnt_r + 8'd1;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/dda_spi_host.sv
`timescale 1ns/1ps
// SPI mode-0 host moving one 32-bit word per frame to/from the DDA responder.
// Start is honoured only while idle; the cs_n gap between frames is CS_GAP half-periods.
module dda_spi_host
  import dda_spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int CS_GAP  = CS_GAP_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam logic [4:0]  LAST_BIT = 5'(FRAME_BITS - 1);
  // The idle cycle after GAP completes the cs_n-high interval, so GAP itself is one shorter.
  localparam logic [11:0] GAP_LAST = 12'(CS_GAP * CLK_DIV - 2);

  logic [2:0]            state_r;
  logic [2:0]            state_nxt_s;
  logic                  clr_s;
  logic                  tick_s;
  logic [FRAME_BITS-1:0] tx_shift_r;
  logic [FRAME_BITS-1:0] rx_shift_r;
  logic [FRAME_BITS-1:0] rx_data_r;
  logic [4:0]            bit_cnt_r;
  logic [11:0]           gap_cnt_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  sclk_r;
  logic                  cs_n_r;
  logic                  mosi_r;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_SETUP;
        else       state_nxt_s = ST_IDLE;
      end
      ST_SETUP: begin
        if (tick_s) state_nxt_s = ST_HIGH;
        else        state_nxt_s = ST_SETUP;
      end
      ST_HIGH: begin
        if (tick_s) state_nxt_s = ST_LOW;
        else        state_nxt_s = ST_HIGH;
      end
      ST_LOW: begin
        if (tick_s && (bit_cnt_r == LAST_BIT)) state_nxt_s = ST_GAP;
        else if (tick_s)                       state_nxt_s = ST_HIGH;
        else                                   state_nxt_s = ST_LOW;
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) state_nxt_s = ST_IDLE;
        else                       state_nxt_s = ST_GAP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Divider restarts on every state change and is parked while idle.
  always_comb begin
    clr_s = (state_nxt_s != state_r) || (state_r == ST_IDLE);
  end

  // FSM state, shift registers and registered SPI outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      tx_shift_r <= '0;
      rx_shift_r <= '0;
      rx_data_r  <= '0;
      bit_cnt_r  <= 5'd0;
      gap_cnt_r  <= 12'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      sclk_r     <= 1'b0;
      cs_n_r     <= 1'b1;
      mosi_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            tx_shift_r <= tx_data;
            rx_shift_r <= '0;
            bit_cnt_r  <= 5'd0;
            cs_n_r     <= 1'b0;
            mosi_r     <= tx_data[FRAME_BITS-1];
            busy_r     <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (tick_s) sclk_r <= 1'b1;
        end
        ST_HIGH: begin
          if (tick_s) begin
            rx_shift_r <= {rx_shift_r[FRAME_BITS-2:0], miso};
            sclk_r     <= 1'b0;
            // Rotating keeps the next bit at [FRAME_BITS-2] without dropping bits.
            if (bit_cnt_r != LAST_BIT) begin
              tx_shift_r <= {tx_shift_r[FRAME_BITS-2:0], tx_shift_r[FRAME_BITS-1]};
              mosi_r     <= tx_shift_r[FRAME_BITS-2];
            end
          end
        end
        ST_LOW: begin
          if (tick_s && (bit_cnt_r == LAST_BIT)) begin
            cs_n_r    <= 1'b1;
            done_r    <= 1'b1;
            rx_data_r <= rx_shift_r;
            mosi_r    <= 1'b0;
            gap_cnt_r <= 12'd0;
          end else if (tick_s) begin
            bit_cnt_r <= bit_cnt_r + 5'd1;
            sclk_r    <= 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) busy_r    <= 1'b0;
          else                       gap_cnt_r <= gap_cnt_r + 12'd1;
        end
        default: begin
          cs_n_r <= 1'b1;
          sclk_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign rx_data = rx_data_r;
  assign sclk    = sclk_r;
  assign cs_n    = cs_n_r;
  assign mosi    = mosi_r;

endmodule

// File: doc/dda_spi_host.md
DDA_SPI_HOST -- requirements
Module: dda_spi_host

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal values are 4..255.
REQ-002 Parameter CS_GAP, default 2: minimum cs_n high time between frames, in SCLK half-periods; legal values are 1..15.
REQ-003 clk  input  1  system clock; all logic is single-clock on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one 32-bit frame; sampled only while busy=0.
REQ-006 tx_data  input  32  word to transmit; captured on the cycle start is accepted.
REQ-007 busy  output  1  high from the cycle after acceptance until the end of the CS_GAP period.
REQ-008 done  output  1  one-cycle pulse when rx_data is updated.
REQ-009 rx_data  output  32  last received word; held until the next done.
REQ-010 sclk  output  1  SPI clock, mode 0, idle low.
REQ-011 cs_n  output  1  chip select, active low, idle high.
REQ-012 mosi  output  1  serial data out, MSB first.
REQ-013 miso  input  1  serial data in, MSB first; treated as synchronous to clk.

Function
REQ-014 States: IDLE, SETUP, HIGH, LOW, GAP.
REQ-015 IDLE + start: capture tx_data into the shift register, clear the bit counter, drive cs_n=0 and mosi=tx_data[31], then enter SETUP.
REQ-016 SETUP: sclk=0 for CLK_DIV cycles, then go to HIGH.
REQ-017 HIGH: sclk=1 for CLK_DIV cycles; on the last HIGH cycle, shift miso into the LSB of the receive register; then go to LOW.
REQ-018 LOW, first cycle: sclk=0; mosi takes the next tx bit, with no update after bit 0.
REQ-019 LOW, after CLK_DIV cycles: bit counter < 31 -> increment and go to HIGH; bit counter = 31 -> go to GAP.
REQ-020 Entering GAP: cs_n=1, rx_data := receive register, done=1 for one cycle.
REQ-021 GAP lasts CS_GAP*CLK_DIV cycles, then go to IDLE with busy=0.
REQ-022 Frame timing: done is asserted exactly 1+65*CLK_DIV cycles after the start-accept edge (261 cycles at CLK_DIV=4).
REQ-023 Exactly 32 rising sclk edges occur per frame; sclk never toggles while cs_n=1.
REQ-024 start while busy=1 is ignored and is not queued.
REQ-025 start held high continuously produces back-to-back frames with cs_n high for exactly CS_GAP*CLK_DIV cycles between them.
REQ-026 Changes to tx_data during a frame have no effect on that frame.
REQ-027 Counters: divider is 8 bits; bit counter is 5 bits with no wrap inside a frame; gap counter is 12 bits.
REQ-028 All outputs are registered; no combinational path exists from start or miso to any output.

Reset
REQ-029 While rst_n=0: state=IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, and all counters and shift registers are 0.
REQ-030 Reset asserted mid-frame aborts the frame immediately, without waiting for clk; no done is generated for the aborted frame.
REQ-031 After rst_n deasserts, the first start is accepted normally.

Structure
REQ-032 Shared package dda_spi_pkg holds FRAME_BITS=32, the state enumeration, and the default CLK_DIV and CS_GAP values; the existing SPI responder imports the same FRAME_BITS.
REQ-033 One sub-module, spi_tick_gen, is a CLK_DIV-cycle half-period counter producing a one-cycle tick; it is cleared on state entry.
REQ-034 Everything else lives in dda_spi_host; target size is 120-400 lines of RTL.

Verification
REQ-035 Loopback (mosi tied to miso), tx_data=32'hA5A5_0F0F, CLK_DIV=4 -> rx_data=32'hA5A5_0F0F; done asserted 261 cycles after start; exactly 32 sclk rising edges.
REQ-036 Behavioural DDA responder model returning {x,y}=32'h3000_3000 and sampling mosi=32'h0000_3C00 -> rx_data=32'h3000_3000; the model receives 32'h0000_3C00 and updates mu to 16'h3C00.
REQ-037 Second start pulse 50 cycles into a frame -> ignored; exactly one done pulse; busy stays continuously high until the end of GAP.
REQ-038 start held high for 3 frames, CS_GAP=2, CLK_DIV=4 -> 3 done pulses; cs_n high for exactly 8 cycles between frames.
REQ-039 rst_n pulsed low at bit 12 -> cs_n=1 and sclk=0 within the same time step, no done; a following frame with 32'hFFFF_0000 completes correctly.
REQ-040 Checker across all scenarios: mosi stable whenever sclk=1; sclk=0 whenever cs_n=1.
